// File: rtl/random_point_sampler_if.sv
// Bundle for random_point_sampler: raw coordinate stream and exclusion cell in,
// accepted grid point with its valid/ack handshake out.
interface random_point_sampler_if;
   logic [9:0] rand_x;
   logic [8:0] rand_y;
   logic       req;
   logic       ack;
   logic       excl_en;
   logic [9:0] excl_x;
   logic [8:0] excl_y;
   logic [9:0] pt_x;
   logic [8:0] pt_y;
   logic       valid;
   logic       busy;
   logic       fallback;
   logic [3:0] tries;

   modport master (
      output rand_x, rand_y, req, ack, excl_en, excl_x, excl_y,
      input  pt_x, pt_y, valid, busy, fallback, tries
   );

   modport slave (
      input  rand_x, rand_y, req, ack, excl_en, excl_x, excl_y,
      output pt_x, pt_y, valid, busy, fallback, tries
   );
endinterface

// File: rtl/random_point_sampler.sv
// Grid-snapping random point picker: resamples off-screen or excluded candidates,
// falls back to a fixed corner after MAX_TRIES rejections, holds the result until ack.
module random_point_sampler #(
   parameter int unsigned X_MAX      = 640,
   parameter int unsigned Y_MAX      = 480,
   parameter int unsigned GRID_SHIFT = 4,
   parameter int unsigned MAX_TRIES  = 15
) (
   input logic                   clk,
   input logic                   rst,
   random_point_sampler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_e;

   localparam logic [9:0]  X_MASK   = 10'(~((32'd1 << GRID_SHIFT) - 32'd1));
   localparam logic [8:0]  Y_MASK   = 9'(~((32'd1 << GRID_SHIFT) - 32'd1));
   localparam logic [10:0] X_LIM    = 11'(X_MAX);
   localparam logic [9:0]  Y_LIM    = 10'(Y_MAX);
   localparam logic [9:0]  X_ALT    = 10'(X_MAX - 1) & X_MASK;
   localparam logic [8:0]  Y_ALT    = 9'(Y_MAX - 1) & Y_MASK;
   localparam logic [3:0]  TRY_LAST = 4'(MAX_TRIES - 1);
   localparam logic [3:0]  TRY_MAX  = 4'(MAX_TRIES);

   state_e     state_q;
   logic [9:0] pt_x_q;
   logic [8:0] pt_y_q;
   logic       valid_q;
   logic       busy_q;
   logic       fallback_q;
   logic [3:0] tries_q;

   logic [9:0] cand_x, excl_ax, fb_x;
   logic [8:0] cand_y, excl_ay, fb_y;
   logic       excl_hit, in_range, accept;

   always_comb begin
      cand_x   = bus.rand_x & X_MASK;
      cand_y   = bus.rand_y & Y_MASK;
      excl_ax  = bus.excl_x & X_MASK;
      excl_ay  = bus.excl_y & Y_MASK;
      in_range = ({1'b0, cand_x} < X_LIM) && ({1'b0, cand_y} < Y_LIM);
      excl_hit = bus.excl_en && (cand_x == excl_ax) && (cand_y == excl_ay);
      accept   = in_range && !excl_hit;
      // Origin is the fallback unless the exclusion cell itself sits at the origin.
      if (bus.excl_en && excl_ax == '0 && excl_ay == '0) begin
         fb_x = X_ALT;
         fb_y = Y_ALT;
      end else begin
         fb_x = '0;
         fb_y = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pt_x_q     <= '0;
         pt_y_q     <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         fallback_q <= 1'b0;
         tries_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req) begin
                  state_q    <= SAMPLE;
                  busy_q     <= 1'b1;
                  tries_q    <= '0;
                  fallback_q <= 1'b0;
               end
            end
            SAMPLE: begin
               if (accept) begin
                  pt_x_q  <= cand_x;
                  pt_y_q  <= cand_y;
                  state_q <= DONE;
                  valid_q <= 1'b1;
               end else if (tries_q >= TRY_LAST) begin
                  pt_x_q     <= fb_x;
                  pt_y_q     <= fb_y;
                  tries_q    <= TRY_MAX;
                  fallback_q <= 1'b1;
                  state_q    <= DONE;
                  valid_q    <= 1'b1;
               end else begin
                  tries_q <= tries_q + 4'd1;
               end
            end
            DONE: begin
               if (bus.ack) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pt_x     = pt_x_q;
   assign bus.pt_y     = pt_y_q;
   assign bus.valid    = valid_q;
   assign bus.busy     = busy_q;
   assign bus.fallback = fallback_q;
   assign bus.tries    = tries_q;
endmodule
